// File: rtl/pll_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : pll_clken_gen
// Purpose  : Lock supervisor and multi-channel clock-enable generator for the
//            PLL output domain. The raw PLL lock is synchronised and debounced
//            (WAIT_LOCK -> SETTLE -> RUN). While in RUN, each channel produces
//            single-cycle enables with its own divide ratio D and start phase P.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_CH          number of enable channels (1..16)
//   CNT_W           width of per-channel divide/phase values and counters
//   LOCK_STABLE_CYC synced-locked cycles spent in SETTLE before RUN (>=1)
// Ports:
//   refclk      in   PLL output clock, rising edge
//   rst         in   asynchronous active-high reset
//   pll_locked  in   raw PLL lock, asynchronous to refclk
//   cfg_load    in   1-cycle strobe capturing div_ratio/phase into shadow regs
//   div_ratio   in   per-channel D, channel i at [i*CNT_W +: CNT_W]
//   phase       in   per-channel P, same packing
//   clk_en      out  per-channel enable pulses
//   locked      out  qualified lock, high only in RUN
//   lock_cnt    out  saturating count of RUN->WAIT_LOCK exits
// Build option:
//   PLL_LOCK_LOSS_CNT_EN  builds the lock-loss counter; otherwise lock_cnt=0.
// ============================================================================
module pll_clken_gen #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 16,
  parameter int LOCK_STABLE_CYC = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic                    cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] div_ratio,
  input  logic [NUM_CH*CNT_W-1:0] phase,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    locked,
  output logic [7:0]              lock_cnt
);

  localparam int STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [1:0]        sync_q;
  logic              lk_s;
  logic              run_w;
  logic              enter_run_w;

  // 2-FF synchroniser for the asynchronous lock input
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lk_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        stab_d = '0;
        if (lk_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (stab_q == STAB_LAST) begin
          state_d = RUN;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      RUN: begin
        if (!lk_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign run_w       = (state_q == RUN);
  assign enter_run_w = (state_q == SETTLE) && (state_d == RUN);
  assign locked      = run_w;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] shd_div_q, shd_ph_q, act_div_q, cnt_q;
      logic [CNT_W-1:0] act_div_eff_w, last_w, shd_div_eff_w, shd_ph_eff_w, src_div_w;
      logic             wrap_w;

      // D=0 behaves as D=1; P>=D behaves as P=0
      assign act_div_eff_w = (act_div_q == '0) ? CNT_W'(1) : act_div_q;
      assign last_w        = act_div_eff_w - CNT_W'(1);
      assign wrap_w        = (cnt_q == last_w);
      assign shd_div_eff_w = (shd_div_q == '0) ? CNT_W'(1) : shd_div_q;
      assign shd_ph_eff_w  = (shd_ph_q >= shd_div_eff_w) ? '0 : shd_ph_q;
      // A strobe coinciding with a wrap must take effect at that wrap
      assign src_div_w     = cfg_load ? div_ratio[i*CNT_W +: CNT_W] : shd_div_q;

      always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
          shd_div_q <= CNT_W'(1);
          shd_ph_q  <= '0;
          act_div_q <= CNT_W'(1);
          cnt_q     <= '0;
        end else begin
          if (cfg_load) begin
            shd_div_q <= div_ratio[i*CNT_W +: CNT_W];
            shd_ph_q  <= phase[i*CNT_W +: CNT_W];
          end
          if (!run_w) begin
            // The entry phase is taken from the same shadow value that
            // becomes active on this edge, so cnt_q always stays below D.
            act_div_q <= shd_div_q;
            cnt_q     <= enter_run_w ? shd_ph_eff_w : '0;
          end else if (wrap_w) begin
            act_div_q <= src_div_w;
            cnt_q     <= '0;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
      end

      assign clk_en[i] = run_w & wrap_w;
    end
  endgenerate

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic       leave_run_w;
  logic [7:0] lcnt_q;

  // RUN only ever exits to WAIT_LOCK
  assign leave_run_w = run_w && (state_d != RUN);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lcnt_q <= 8'd0;
    end else if (leave_run_w && (lcnt_q != 8'hFF)) begin
      lcnt_q <= lcnt_q + 8'd1;
    end
  end

  assign lock_cnt = lcnt_q;
`else
  assign lock_cnt = 8'd0;
`endif

endmodule
`default_nettype wire
